// File: rtl/blowfish128_ffunc_arb.sv
// Round-robin arbiter sharing one Blowfish F-function unit between the key-schedule
// generator (requester 0) and the encrypt core (requester 1), with a WAIT timeout.
module blowfish128_ffunc_arb #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        req0_enable,
  input  logic [63:0] req0_X,
  output logic [63:0] req0_Y,
  output logic        req0_ready,
  input  logic        req1_enable,
  input  logic [63:0] req1_X,
  output logic [63:0] req1_Y,
  output logic        req1_ready,
  output logic        f_enable,
  output logic [63:0] f_X,
  input  logic [63:0] f_Y,
  input  logic        f_ready,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_t      state_r, state_s;
  logic        f_enable_r, f_enable_s;
  logic [63:0] f_x_r, f_x_s;
  logic        grant_r, grant_s;
  logic        last_r, last_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [63:0] y0_r, y0_s;
  logic [63:0] y1_r, y1_s;
  logic        rdy0_r, rdy0_s;
  logic        rdy1_r, rdy1_s;
  logic        busy_r, busy_s;
  logic        err_r, err_s;
  logic        pick_s;

  // State and output registers; last-served resets to 1 so requester 0 wins first.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r    <= IDLE;
      f_enable_r <= 1'b0;
      f_x_r      <= 64'd0;
      grant_r    <= 1'b0;
      last_r     <= 1'b1;
      cnt_r      <= 8'd0;
      y0_r       <= 64'd0;
      y1_r       <= 64'd0;
      rdy0_r     <= 1'b0;
      rdy1_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      f_enable_r <= f_enable_s;
      f_x_r      <= f_x_s;
      grant_r    <= grant_s;
      last_r     <= last_s;
      cnt_r      <= cnt_s;
      y0_r       <= y0_s;
      y1_r       <= y1_s;
      rdy0_r     <= rdy0_s;
      rdy1_r     <= rdy1_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
    end
  end

  // Next-state and next-output logic; ready pulses default low every cycle.
  always_comb begin
    state_s    = state_r;
    f_enable_s = f_enable_r;
    f_x_s      = f_x_r;
    grant_s    = grant_r;
    last_s     = last_r;
    cnt_s      = cnt_r;
    y0_s       = y0_r;
    y1_s       = y1_r;
    rdy0_s     = 1'b0;
    rdy1_s     = 1'b0;
    err_s      = err_r;
    pick_s     = 1'b0;
    busy_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (req0_enable && req1_enable) begin
          pick_s = ~last_r;
        end else begin
          pick_s = req1_enable;
        end
        if (req0_enable || req1_enable) begin
          f_x_s   = pick_s ? req1_X : req0_X;
          grant_s = pick_s;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        f_enable_s = 1'b1;
        cnt_s      = 8'd0;
        state_s    = WAIT;
      end
      WAIT: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (f_ready) begin
          if (grant_r) begin
            y1_s   = f_Y;
            rdy1_s = 1'b1;
          end else begin
            y0_s   = f_Y;
            rdy0_s = 1'b1;
          end
          f_enable_s = 1'b0;
          last_s     = grant_r;
          state_s    = RELEASE;
        end else if (cnt_r + 8'd1 == TIMEOUT_LIM) begin
          err_s      = 1'b1;
          f_enable_s = 1'b0;
          last_s     = grant_r;
          state_s    = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RELEASE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  assign f_enable    = f_enable_r;
  assign f_X         = f_x_r;
  assign grant       = grant_r;
  assign req0_Y      = y0_r;
  assign req1_Y      = y1_r;
  assign req0_ready  = rdy0_r;
  assign req1_ready  = rdy1_r;
  assign busy        = busy_r;
  assign timeout_err = err_r;

endmodule

// File: tb/tb_blowfish128_ffunc_arb.sv
// Scoreboard bench for blowfish128_ffunc_arb: requesters push expected results,
// a negedge monitor pops them on every ready pulse; a responder models the F unit.
module tb_blowfish128_ffunc_arb;

  logic        Clk;
  logic        RstN;
  logic        req0_enable, req1_enable;
  logic [63:0] req0_X, req1_X;
  logic [63:0] req0_Y, req1_Y;
  logic        req0_ready, req1_ready;
  logic        f_enable;
  logic [63:0] f_X;
  logic [63:0] f_Y;
  logic        f_ready;
  logic        grant, busy, timeout_err;

  blowfish128_ffunc_arb #(.TIMEOUT_CYC(4)) dut (
    .Clk(Clk), .RstN(RstN),
    .req0_enable(req0_enable), .req0_X(req0_X), .req0_Y(req0_Y), .req0_ready(req0_ready),
    .req1_enable(req1_enable), .req1_X(req1_X), .req1_Y(req1_Y), .req1_ready(req1_ready),
    .f_enable(f_enable), .f_X(f_X), .f_Y(f_Y), .f_ready(f_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] issued[$];
  logic [63:0] ly0, ly1;
  logic        pr0, pr1;
  int          r0_cnt = 0, r1_cnt = 0;
  int          rsp_mode = 0;       // 0: random delay 0..3, 1: delay 3 fixed Y, 2: silent
  logic [63:0] rsp_y = 64'd0;
  int          spur_cnt = 0, spur_done = 0;
  logic        bb_win = 1'b0;
  int          idle_cnt = 0;

  // Reference F function used by the responder and by the expected values.
  function automatic logic [63:0] fref(input logic [63:0] x);
    return ({x[31:0], x[63:32]} ^ 64'h9E37_79B9_7F4A_7C15) + x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_f_enable"}, 64'(f_enable), 64'd0);
    chk({tag, "_f_X"}, f_X, 64'd0);
    chk({tag, "_req0_Y"}, req0_Y, 64'd0);
    chk({tag, "_req1_Y"}, req1_Y, 64'd0);
    chk({tag, "_req0_ready"}, 64'(req0_ready), 64'd0);
    chk({tag, "_req1_ready"}, 64'(req1_ready), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  // Holds enable until this requester's ready pulse; returns in the RELEASE cycle.
  task automatic req_txn(input int id, input logic [63:0] x, input logic [63:0] y_exp);
    bit got = 1'b0;
    if (id == 0) begin
      q0.push_back(y_exp); req0_X = x; req0_enable = 1'b1;
    end else begin
      q1.push_back(y_exp); req1_X = x; req1_enable = 1'b1;
    end
    for (int c = 0; c < 64 && !got; c++) begin
      step();
      got = (id == 0) ? req0_ready : req1_ready;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL req%0d_wait: got no ready within 64 cycles, expected a ready pulse", id);
    end
    if (id == 0) begin
      req0_enable = 1'b0; req0_X = {$urandom, $urandom};
    end else begin
      req1_enable = 1'b0; req1_X = {$urandom, $urandom};
    end
  endtask

  task automatic apply_reset;
    RstN = 1'b0;
    req0_enable = 1'b0;
    req1_enable = 1'b0;
    repeat (2) step();
    chk_zero("rst");
    RstN = 1'b1;
  endtask

  // F-unit responder: owns f_ready/f_Y, records each issued operand.
  initial begin
    bit fen_seen = 1'b0;
    int d;
    f_ready = 1'b0;
    f_Y = 64'd0;
    forever begin
      step();
      if (spur_cnt != spur_done) begin
        f_Y = 64'hFFFF_FFFF_FFFF_FFFF;
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        spur_done++;
      end else if (f_enable && !fen_seen) begin
        fen_seen = 1'b1;
        issued.push_back(f_X);
        if (rsp_mode != 2) begin
          d = (rsp_mode == 1) ? 3 : int'($urandom_range(0, 3));
          repeat (d) begin
            step();
            chk("f_X_stable", f_X, issued[$]);
            chk("f_enable_held", 64'(f_enable), 64'd1);
          end
          f_Y = (rsp_mode == 1) ? rsp_y : fref(f_X);
          f_ready = 1'b1;
          step();
          f_ready = 1'b0;
          f_Y = {$urandom, $urandom};
        end
      end
      if (!f_enable) fen_seen = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each ready pulse, otherwise Y must hold.
  initial begin
    logic [63:0] e;
    ly0 = 64'd0; ly1 = 64'd0; pr0 = 1'b0; pr1 = 1'b0;
    forever begin
      @(negedge Clk);
      if (!RstN) begin
        ly0 = 64'd0; ly1 = 64'd0; pr0 = 1'b0; pr1 = 1'b0;
      end else begin
        if (req0_ready) begin
          r0_cnt++;
          chk("req0_ready_width", 64'(pr0), 64'd0);
          if (q0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req0_unexpected_ready: got ready with Y %h, expected no pulse", req0_Y);
          end else begin
            e = q0.pop_front();
            chk("req0_Y", req0_Y, e);
            ly0 = e;
          end
        end else begin
          chk("req0_Y_hold", req0_Y, ly0);
        end
        if (req1_ready) begin
          r1_cnt++;
          chk("req1_ready_width", 64'(pr1), 64'd0);
          if (q1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL req1_unexpected_ready: got ready with Y %h, expected no pulse", req1_Y);
          end else begin
            e = q1.pop_front();
            chk("req1_Y", req1_Y, e);
            ly1 = e;
          end
        end else begin
          chk("req1_Y_hold", req1_Y, ly1);
        end
        pr0 = req0_ready;
        pr1 = req1_ready;
      end
      if (bb_win && !busy) idle_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x;
    logic [63:0] exp_ord[4];
    int n_before;
    exp_ord[0] = 64'd1; exp_ord[1] = 64'd2; exp_ord[2] = 64'd3; exp_ord[3] = 64'd4;
    RstN = 1'b0;
    req0_enable = 1'b0; req1_enable = 1'b0;
    req0_X = 64'd0; req1_X = 64'd0;
    repeat (3) step();
    chk_zero("reset");
    RstN = 1'b1;

    // Single request from requester 1 with exact cycle timing.
    rsp_mode = 1;
    rsp_y = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    fork
      req_txn(1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D);
      begin
        step();
        chk("t1_grant", 64'(grant), 64'd1);
        chk("t1_f_X", f_X, 64'h0123_4567_89AB_CDEF);
        chk("t1_f_enable_c1", 64'(f_enable), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        step();
        chk("t1_f_enable_c2", 64'(f_enable), 64'd1);
        repeat (4) step();
        chk("t1_ready_c6", 64'(req1_ready), 64'd1);
        chk("t1_req1_Y", req1_Y, 64'hDEAD_BEEF_CAFE_F00D);
        chk("t1_f_enable_c6", 64'(f_enable), 64'd0);
        step();
        chk("t1_busy_c7", 64'(busy), 64'd0);
        chk("t1_no_timeout", 64'(timeout_err), 64'd0);
      end
    join

    // Round-robin on simultaneous requests right after reset.
    rsp_mode = 0;
    apply_reset();
    issued.delete();
    fork
      req_txn(0, 64'd1, fref(64'd1));
      req_txn(1, 64'd2, fref(64'd2));
    join
    fork
      req_txn(0, 64'd3, fref(64'd3));
      req_txn(1, 64'd4, fref(64'd4));
    join
    chk("rr_count", 64'(issued.size()), 64'd4);
    for (int i = 0; i < issued.size() && i < 4; i++) chk("rr_order", issued[i], exp_ord[i]);

    // Back-to-back requester 1: one idle cycle between transactions.
    n_before = r1_cnt;
    x = {$urandom, $urandom};
    req_txn(1, x, fref(x));
    idle_cnt = 0;
    bb_win = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      x = {$urandom, $urandom};
      req_txn(1, x, fref(x));
    end
    bb_win = 1'b0;
    chk("b2b_idle_cycles", 64'(idle_cnt), 64'd7);
    chk("b2b_ready_count", 64'(r1_cnt - n_before), 64'd8);

    // Timeout with a silent F unit.
    rsp_mode = 2;
    step();
    req0_X = {$urandom, $urandom};
    req0_enable = 1'b1;
    step();
    req0_enable = 1'b0;
    chk("to_busy", 64'(busy), 64'd1);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("to_f_enable_wait", 64'(f_enable), 64'd1);
      chk("to_err_clear", 64'(timeout_err), 64'd0);
    end
    step();
    chk("to_f_enable_drop", 64'(f_enable), 64'd0);
    chk("to_err_set", 64'(timeout_err), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    rsp_mode = 0;
    x = {$urandom, $urandom};
    req_txn(0, x, fref(x));
    x = {$urandom, $urandom};
    req_txn(1, x, fref(x));
    chk("to_err_sticky", 64'(timeout_err), 64'd1);

    // Reset during WAIT, then a late f_ready.
    rsp_mode = 2;
    step();
    req1_X = {$urandom, $urandom};
    req1_enable = 1'b1;
    step();
    req1_enable = 1'b0;
    repeat (2) step();
    RstN = 1'b0;
    #1;
    chk_zero("midrst");
    step();
    RstN = 1'b1;
    spur_cnt++;
    repeat (3) begin
      step();
      chk("midrst_idle", 64'(busy), 64'd0);
    end
    rsp_mode = 0;
    x = {$urandom, $urandom};
    req_txn(1, x, fref(x));

    // Spurious f_ready while idle.
    rsp_mode = 2;
    step();
    spur_cnt++;
    repeat (3) begin
      step();
      chk("spur_idle", 64'(busy), 64'd0);
      chk("spur_f_enable", 64'(f_enable), 64'd0);
    end
    rsp_mode = 0;

    // Random traffic from both requesters.
    fork
      repeat (12) begin
        repeat ($urandom_range(0, 3)) step();
        x = {$urandom, $urandom};
        req_txn(0, x, fref(x));
      end
      begin
        logic [63:0] x1;
        repeat (12) begin
          repeat ($urandom_range(0, 3)) step();
          x1 = {$urandom, $urandom};
          req_txn(1, x1, fref(x1));
        end
      end
    join

    repeat (4) step();
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
